// File: rtl/isa_pkg.sv
// Shared definitions for the ISA I/O cycle master: FSM encoding,
// command control bit positions and default bus timing.
package isa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int CTRL_START = 0;
    localparam int CTRL_RNW   = 1;
    localparam int CTRL_WIDE  = 2;

    localparam int DEF_SETUP_CYCLES   = 3;
    localparam int DEF_STROBE_CYCLES  = 12;
    localparam int DEF_HOLD_CYCLES    = 3;
    localparam int DEF_TIMEOUT_CYCLES = 2048;
    localparam int DEF_CNT_W          = 12;

endpackage

// File: rtl/isa_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// selectable value taken while in reset.
module isa_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/isa_io_cycle_master.sv
// Runs a single ISA I/O read or write cycle on the slot bus from a latched
// register-file command, returning read data through a one-cycle load strobe.
module isa_io_cycle_master
    import isa_pkg::*;
#(
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_cmd_addr,
    input  logic [15:0] i_cmd_wdata,
    input  logic [7:0]  i_cmd_ctrl,
    output logic [15:0] o_isa_sa,
    output logic [15:0] o_isa_sd_out,
    output logic        o_isa_sd_oe,
    input  logic [15:0] i_isa_sd_in,
    output logic        o_isa_ior_n,
    output logic        o_isa_iow_n,
    output logic        o_isa_aen,
    output logic        o_isa_bale,
    input  logic        i_isa_iochrdy,
    output logic [15:0] o_rd_data,
    output logic        o_rd_load,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout
);

    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LIMIT = CNT_W'(TIMEOUT_CYCLES - STROBE_CYCLES);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_start_prev;
    logic             r_rnw;
    logic             r_wide;
    logic             w_start_edge;
    logic             w_rdy;
    logic             w_strobe_exit;
    logic             w_timeout_hit;
    logic             w_unused_ctrl;

    assign w_start_edge  = i_cmd_ctrl[CTRL_START] & ~r_start_prev;
    assign w_unused_ctrl = ^i_cmd_ctrl[7:3];

    isa_sync2 #(.RESET_VAL(1'b1)) u_rdy_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_isa_iochrdy),
        .o_q     (w_rdy)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_start_prev <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_start_prev <= i_cmd_ctrl[CTRL_START];
        end
    end

    // In STROBE the counter runs down from the timeout limit, so elapsed
    // strobe time is implied by how far it has fallen.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_strobe_exit = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_state_next = ST_SETUP;
                    w_cnt_next   = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_STROBE;
                    w_cnt_next   = STROBE_LOAD;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (r_cnt <= STROBE_LIMIT && w_rdy) begin
                    w_strobe_exit = 1'b1;
                    w_state_next  = ST_HOLD;
                    w_cnt_next    = HOLD_LOAD;
                end else if (r_cnt == '0) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = ST_HOLD;
                    w_cnt_next    = HOLD_LOAD;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Bus outputs are registered from the next state so they change on the
    // same edge as the FSM; address and write data live in the output flops.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rnw        <= 1'b0;
            r_wide       <= 1'b0;
            o_isa_sa     <= '0;
            o_isa_sd_out <= '0;
            o_isa_sd_oe  <= 1'b0;
            o_isa_ior_n  <= 1'b1;
            o_isa_iow_n  <= 1'b1;
            o_isa_aen    <= 1'b1;
            o_isa_bale   <= 1'b0;
            o_rd_data    <= '0;
            o_rd_load    <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_rd_load   <= 1'b0;
            o_done      <= 1'b0;
            o_isa_bale  <= 1'b0;
            o_isa_ior_n <= ~(w_state_next == ST_STROBE && r_rnw);
            o_isa_iow_n <= ~(w_state_next == ST_STROBE && !r_rnw);
            if (r_state == ST_IDLE && w_start_edge) begin
                r_rnw        <= i_cmd_ctrl[CTRL_RNW];
                r_wide       <= i_cmd_ctrl[CTRL_WIDE];
                o_isa_sa     <= i_cmd_addr;
                o_isa_sd_out <= i_cmd_ctrl[CTRL_WIDE] ? i_cmd_wdata
                                                      : {8'h00, i_cmd_wdata[7:0]};
                o_isa_sd_oe  <= ~i_cmd_ctrl[CTRL_RNW];
                o_isa_aen    <= 1'b0;
                o_isa_bale   <= 1'b1;
                o_busy       <= 1'b1;
                o_timeout    <= 1'b0;
            end
            if (w_strobe_exit && r_rnw) begin
                o_rd_data <= r_wide ? i_isa_sd_in : {8'h00, i_isa_sd_in[7:0]};
                o_rd_load <= 1'b1;
            end
            if (w_timeout_hit) begin
                o_timeout <= 1'b1;
            end
            if (w_state_next == ST_DONE) begin
                o_done      <= 1'b1;
                o_isa_aen   <= 1'b1;
                o_isa_sd_oe <= 1'b0;
            end
            if (w_state_next == ST_IDLE) begin
                o_isa_aen   <= 1'b1;
                o_isa_sd_oe <= 1'b0;
                o_busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_isa_io_cycle_master.sv
// Randomised bench for isa_io_cycle_master: each bus cycle is predicted from
// the timing rules and compared with what is observed on the slot bus.
module tb_isa_io_cycle_master;

   localparam int SETUP   = 3;
   localparam int STROBE  = 12;
   localparam int HOLD    = 3;
   localparam int TIMEOUT = 2048;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cmdAddr;
   logic [15:0] cmdWdata;
   logic [7:0]  cmdCtrl;
   logic [15:0] sdIn;
   logic        iochrdy;
   logic [15:0] isaSa;
   logic [15:0] isaSdOut;
   logic        isaSdOe;
   logic        iorN;
   logic        iowN;
   logic        aen;
   logic        bale;
   logic [15:0] rdData;
   logic        rdLoad;
   logic        busy;
   logic        done;
   logic        timeoutFlag;

   int checkCount = 0;
   int errorCount = 0;

   // 50 MHz clock; all stimulus and sampling happens on the falling edge
   always #10 clk = ~clk;

   isa_io_cycle_master dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_cmd_addr    (cmdAddr),
      .i_cmd_wdata   (cmdWdata),
      .i_cmd_ctrl    (cmdCtrl),
      .o_isa_sa      (isaSa),
      .o_isa_sd_out  (isaSdOut),
      .o_isa_sd_oe   (isaSdOe),
      .i_isa_sd_in   (sdIn),
      .o_isa_ior_n   (iorN),
      .o_isa_iow_n   (iowN),
      .o_isa_aen     (aen),
      .o_isa_bale    (bale),
      .i_isa_iochrdy (iochrdy),
      .o_rd_data     (rdData),
      .o_rd_load     (rdLoad),
      .o_busy        (busy),
      .o_done        (done),
      .o_timeout     (timeoutFlag)
   );

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Runs one bus cycle. nLow: 0 = device always ready, >0 = IOCHRDY held low
   // for that many strobe clocks (counting the clock the strobe falls on),
   // <0 = IOCHRDY stuck low. bumpStart re-pulses start in mid-strobe.
   task automatic applyStimulus(input bit rnw, input bit wide, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] sdVal,
                                input int nLow, input bit bumpStart);
      int expWidth;
      bit expTo;
      logic [15:0] expRd;
      logic [15:0] expSd;
      int cyc = 0;
      int baleCnt = 0;
      int baleAtOne = 0;
      int setupCnt = -1;
      int strobeCnt = 0;
      int holdCnt = 0;
      int oeCnt = 0;
      int sdBad = 0;
      int saBad = 0;
      int wrongStrobe = 0;
      int loadCnt = 0;
      int latency = 0;
      int extra = 0;
      logic [15:0] loadData = 16'h0;
      bit finished = 1'b0;

      // Reference model: strobe width is the minimum width or the ready delay
      // plus two synchroniser clocks, capped by the timeout.
      if (nLow < 0 || nLow + 2 >= TIMEOUT) begin
         expWidth = TIMEOUT;
         expTo    = 1'b1;
      end else begin
         expWidth = (nLow + 2 > STROBE) ? nLow + 2 : STROBE;
         expTo    = 1'b0;
      end
      expRd = wide ? sdVal : {8'h00, sdVal[7:0]};
      expSd = wide ? wdata : {8'h00, wdata[7:0]};

      @(negedge clk);
      cmdCtrl  = {5'b0, wide, rnw, 1'b0};
      cmdAddr  = addr;
      cmdWdata = wdata;
      iochrdy  = (nLow == 0);
      sdIn     = (nLow == 0) ? sdVal : 16'($urandom);
      @(negedge clk);
      cmdCtrl[0] = 1'b1;

      while (!finished && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            cmdAddr  = ~addr;
            cmdWdata = ~wdata;
            checkOutput("timeout_clear_on_accept", 32'(timeoutFlag), 32'(0));
            checkOutput("busy_after_accept", 32'(busy), 32'(1));
            baleAtOne = int'(bale);
         end
         if (bale) baleCnt++;
         if (!iorN || !iowN) begin
            strobeCnt++;
            if (strobeCnt == 1) setupCnt = cyc - 1;
            if (rnw ? !iowN : !iorN) wrongStrobe++;
            if (nLow > 0 && strobeCnt == nLow) begin
               iochrdy = 1'b1;
               sdIn    = sdVal;
            end
            if (bumpStart && strobeCnt == 4) cmdCtrl[0] = 1'b0;
            if (bumpStart && strobeCnt == 6) cmdCtrl[0] = 1'b1;
         end else if (strobeCnt > 0 && !aen) begin
            holdCnt++;
            if (holdCnt == 1) sdIn = ~sdVal;
         end
         if (!aen && isaSa !== addr) saBad++;
         if (isaSdOe) begin
            oeCnt++;
            if (isaSdOut !== expSd) sdBad++;
         end
         if (rdLoad) begin
            loadCnt++;
            loadData = rdData;
         end
         if (done) begin
            latency  = cyc;
            finished = 1'b1;
         end
      end

      checkOutput("done_seen", 32'(finished), 32'(1));
      checkOutput("bale_first_cycle", 32'(baleAtOne), 32'(1));
      checkOutput("bale_width", 32'(baleCnt), 32'(1));
      checkOutput("setup_cycles", 32'(setupCnt), 32'(SETUP));
      checkOutput("strobe_width", 32'(strobeCnt), 32'(expWidth));
      checkOutput("hold_cycles", 32'(holdCnt), 32'(HOLD));
      checkOutput("latency_to_done", 32'(latency), 32'(SETUP + expWidth + HOLD + 1));
      checkOutput("wrong_strobe", 32'(wrongStrobe), 32'(0));
      checkOutput("address_held", 32'(saBad), 32'(0));
      checkOutput("sd_oe_cycles", 32'(oeCnt), 32'(rnw ? 0 : SETUP + expWidth + HOLD));
      checkOutput("sd_out_value", 32'(sdBad), 32'(0));
      checkOutput("rd_load_count", 32'(loadCnt), 32'((rnw && !expTo) ? 1 : 0));
      if (rnw && !expTo) checkOutput("rd_data", 32'(loadData), 32'(expRd));

      @(negedge clk);
      checkOutput("busy_after_done", 32'(busy), 32'(0));
      checkOutput("done_single_pulse", 32'(done), 32'(0));
      checkOutput("aen_after_done", 32'(aen), 32'(1));
      checkOutput("timeout_flag", 32'(timeoutFlag), 32'(expTo));
      if (nLow < 0) iochrdy = 1'b1;

      if (bumpStart) begin
         repeat (25) begin
            @(negedge clk);
            if (done || busy) extra++;
         end
         checkOutput("start_while_busy_ignored", 32'(extra), 32'(0));
      end
   endtask

   // Starts a write and asynchronously resets it in the middle of the strobe
   task automatic applyResetMidWrite();
      int waitCyc = 0;
      @(negedge clk);
      cmdCtrl  = 8'h00;
      cmdAddr  = 16'h0280;
      cmdWdata = 16'h1234;
      iochrdy  = 1'b1;
      @(negedge clk);
      cmdCtrl[0] = 1'b1;
      while (iowN && waitCyc < 50) begin
         @(negedge clk);
         waitCyc++;
      end
      checkOutput("rst_strobe_reached", 32'(iowN), 32'(0));
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("rst_iow_n", 32'(iowN), 32'(1));
      checkOutput("rst_ior_n", 32'(iorN), 32'(1));
      checkOutput("rst_aen", 32'(aen), 32'(1));
      checkOutput("rst_sd_oe", 32'(isaSdOe), 32'(0));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int activity = 0;
      bit rnw;
      bit wide;
      int nLow;
      reset    = 1'b1;
      cmdCtrl  = 8'h01;
      cmdAddr  = 16'h0;
      cmdWdata = 16'h0;
      sdIn     = 16'h0;
      iochrdy  = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("reset_sa", 32'(isaSa), 32'(0));
      checkOutput("reset_sd_out", 32'(isaSdOut), 32'(0));
      checkOutput("reset_sd_oe", 32'(isaSdOe), 32'(0));
      checkOutput("reset_ior_n", 32'(iorN), 32'(1));
      checkOutput("reset_iow_n", 32'(iowN), 32'(1));
      checkOutput("reset_aen", 32'(aen), 32'(1));
      checkOutput("reset_bale", 32'(bale), 32'(0));
      checkOutput("reset_rd_data", 32'(rdData), 32'(0));
      checkOutput("reset_rd_load", 32'(rdLoad), 32'(0));
      checkOutput("reset_busy", 32'(busy), 32'(0));
      checkOutput("reset_done", 32'(done), 32'(0));
      checkOutput("reset_timeout", 32'(timeoutFlag), 32'(0));

      // Start bit is already high when reset releases: nothing must run
      reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (busy || bale || done || !aen) activity++;
      end
      checkOutput("start_high_at_reset", 32'(activity), 32'(0));

      applyStimulus(1'b0, 1'b0, 16'h0226, 16'h00A5, 16'h0000, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h022A, 16'h0000, 16'h12AA, 0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0300, 16'h0000, 16'hBEEF, 40, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0310, 16'h0000, 16'h5A5A, -1, 1'b0);
      repeat (5) @(negedge clk);
      checkOutput("timeout_sticky", 32'(timeoutFlag), 32'(1));
      applyStimulus(1'b0, 1'b1, 16'h0320, 16'hC3C3, 16'h0000, 0, 1'b1);
      applyResetMidWrite();
      applyStimulus(1'b0, 1'b1, 16'h0284, 16'h8001, 16'h0000, 0, 1'b0);

      for (int t = 0; t < 20; t++) begin
         rnw  = 1'($urandom_range(0, 1));
         wide = 1'($urandom_range(0, 1));
         nLow = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 50));
         applyStimulus(rnw, wide, 16'($urandom), 16'($urandom), 16'($urandom),
                       nLow, ($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/isa_io_cycle_master.md
Name: isa_io_cycle_master

Overview:
Bus-side consumer of the HPS register file. It takes the latched command (address, write data, control) and runs one ISA I/O read or write cycle on the riser's slot bus (SA/SD, IOR#/IOW#, AEN, BALE, IOCHRDY). On reads it returns the captured SD data to the register file's data register through a one-cycle load strobe. It reports busy, done and timeout status.

Parameters:
SETUP_CYCLES, 3, clocks from address/AEN valid to strobe assertion (min 1)
STROBE_CYCLES, 12, minimum clocks IOR#/IOW# held low (min 2)
HOLD_CYCLES, 3, clocks address/write data held after strobe deassertion (min 1)
TIMEOUT_CYCLES, 2048, maximum clocks IOCHRDY may stretch a strobe before abort
CNT_W, 12, width of the internal down-counter; must hold max(all above)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
cmd_addr  in  16  I/O address, from address register
cmd_wdata  in  16  write data, from data register
cmd_ctrl  in  8  control register: [0] start, [1] rnw (1=read), [2] wide (1=16-bit)
isa_sa  out  16  ISA address
isa_sd_out  out  16  ISA data out
isa_sd_oe  out  1  SD output enable (write cycles only)
isa_sd_in  in  16  ISA data in
isa_ior_n  out  1  I/O read strobe, active low
isa_iow_n  out  1  I/O write strobe, active low
isa_aen  out  1  address enable, high when not our cycle
isa_bale  out  1  address latch enable
isa_iochrdy  in  1  asynchronous channel ready; low stretches the cycle
rd_data  out  16  captured read data
rd_load  out  1  one-cycle strobe: load rd_data into the data register
busy  out  1  cycle in progress
done  out  1  one-cycle pulse at cycle end
timeout  out  1  sticky; set on IOCHRDY timeout, cleared by the next start

Behaviour:
- Reset (async, any state): FSM to IDLE. isa_ior_n=isa_iow_n=1, isa_aen=1, isa_bale=0, isa_sd_oe=0, isa_sa=0, isa_sd_out=0, rd_data=0, rd_load=0, busy=0, done=0, timeout=0. Start edge detector primed to 1, so a start bit already high at reset release does not trigger. The IOCHRDY synchroniser is reset to 1.
- Start: rising edge of cmd_ctrl[0], sampled on clk. Accepted only in IDLE; edges seen while busy are dropped and not queued.
- On accept: cmd_addr, cmd_wdata, rnw and wide are latched; later command changes have no effect on the running cycle. timeout is cleared. busy=1 from the next cycle.
- When wide=0: isa_sd_out[15:8]=0 and rd_data[15:8]=0.
- SETUP: count SETUP_CYCLES. isa_sa=latched address, isa_aen=0. isa_bale=1 on the first SETUP cycle only. On writes, isa_sd_oe=1 and isa_sd_out is driven from the first SETUP cycle.
- STROBE: isa_ior_n or isa_iow_n low. Leave STROBE when at least STROBE_CYCLES have elapsed and the synchronised IOCHRDY=1.
  - IOCHRDY uses a 2-FF synchroniser, so its latency is 2 clocks; the minimum strobe width is exactly STROBE_CYCLES.
  - If the total strobe time reaches TIMEOUT_CYCLES: set timeout and go to HOLD. No rd_load is issued on a timed-out read.
- Read capture: isa_sd_in is registered on the last STROBE cycle (the cycle the strobe deasserts after). rd_load pulses on the first HOLD cycle with that value.
- HOLD: strobe high. Address, AEN=0 and write data with sd_oe remain held for HOLD_CYCLES.
- DONE: single cycle. done=1, isa_aen=1, isa_sd_oe=0, busy=0 on the next cycle, return to IDLE.
- Normal read latency from accept: SETUP+STROBE+HOLD+1 clocks to done.
- States: IDLE, SETUP, STROBE, HOLD, DONE. Invalid encodings recover to IDLE.
- All outputs are registered.

Decomposition:
- Package isa_pkg: FSM state encoding, control bit indices (CTRL_START=0, CTRL_RNW=1, CTRL_WIDE=2), default timing constants.
- One sub-module, isa_sync2: 2-FF synchroniser with a reset value parameter, used for IOCHRDY.

Test Plan:
- Write: addr=0x0226, wdata=0x00A5, ctrl 0x00->0x01.
  - Required: BALE for 1 clk; IOW# low exactly 12 clks, starting 3 clks after AEN falls; SD=0x00A5, oe=1 through HOLD; done pulses once; no rd_load.
- Read 8-bit: addr=0x022A, isa_sd_in=0x12AA, ctrl 0x03, IOCHRDY=1.
  - Required: IOR# low 12 clks; rd_load one pulse with rd_data=0x00AA; sd_oe=0 throughout.
- Wait states: read with IOCHRDY held low for 40 clks after the strobe falls.
  - Required: IOR# low for 42 clks (40 + 2 sync); rd_data latched after release; timeout=0.
- Timeout: IOCHRDY stuck low.
  - Required: strobe released after 2048 clks; timeout=1, sticky; no rd_load; done pulses.
  - Then start a new cycle: timeout clears on accept.
- Start while busy: second 0->1 edge of ctrl[0] in mid-STROBE.
  - Required: ignored; exactly one done. Start held high at reset release: no cycle.
- Reset mid-STROBE of a write.
  - Required: IOW#=1, AEN=1, sd_oe=0 immediately (async); busy=0; a subsequent start runs a normal cycle.
